// File: rtl/recalque_pkg.sv
// recalque_pkg: shared types and constants for the recalque (pump-up) scheduler.
//   state_t        scheduler FSM states
//   NTANKS         number of upper tanks served by the shared pump
//   *_CYCLES_DEF   default settle / cooldown lengths
//   timer_width()  down-counter width for a given largest cycle count
package recalque_pkg;

    localparam int NTANKS              = 2;
    localparam int SETTLE_CYCLES_DEF   = 4;
    localparam int COOLDOWN_CYCLES_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_PUMPING,
        ST_COOLDOWN
    } state_t;

    // Timers are loaded with (cycles - 1) and count down to zero, so a
    // counter of $clog2(cycles) bits is enough.
    function automatic int timer_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/recalque_timer.sv
// recalque_timer: loadable down-counter with terminal-count flag.
//   i_clk       clock
//   i_reset     synchronous active-high reset (count -> 0)
//   i_load      load i_load_val (takes priority over i_dec)
//   i_load_val  value loaded; load (cycles - 1) for a span of `cycles` edges
//   i_dec       decrement by one, saturating at zero
//   o_done      count is zero
module recalque_timer #(
    parameter int WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/recalque_scheduler.sv
// recalque_scheduler: shares one pump between two upper tanks fed from a
// cistern. Opens the routing valve, lets it settle, runs the pump until the
// served tank is full (or the cistern runs low / a sensor fault appears),
// then enforces a pump-off cooldown. Ties alternate between tanks.
//   clk_2               clock, rising edge
//   reset               synchronous active-high reset
//   cisterna_nivel_min  1 = cistern at/above minimum level
//   caixa_nivel_max[i]  tank i maximum-level sensor
//   caixa_nivel_min[i]  tank i minimum-level sensor
//   bomba_acionada      pump on
//   valvula_en          routing valve open
//   valvula_sel         tank the valve routes to
//   inconsistencia[i]   sticky sensor fault for tank i (max set, min clear)
//   busy                FSM not idle
//   timeout             (RECALQUE_WATCHDOG_EN only) sticky pumping watchdog trip
// Optional feature: define RECALQUE_WATCHDOG_EN to bound PUMPING to
// MAX_PUMP_CYCLES cycles and lock out the tank that tripped it.
//
// state    | meaning
// IDLE     | valve closed, waiting for a request with cistern water
// SETTLE   | valve open to granted tank, pump still off
// PUMPING  | pump on into granted tank
// COOLDOWN | pump off, minimum off-time before the next grant
module recalque_scheduler
    import recalque_pkg::*;
#(
    parameter int SETTLE_CYCLES   = SETTLE_CYCLES_DEF,
    parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
    parameter int MAX_PUMP_CYCLES = 1000
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic              cisterna_nivel_min,
    input  logic [NTANKS-1:0] caixa_nivel_max,
    input  logic [NTANKS-1:0] caixa_nivel_min,
    output logic              bomba_acionada,
    output logic              valvula_en,
    output logic              valvula_sel,
    output logic [NTANKS-1:0] inconsistencia,
`ifdef RECALQUE_WATCHDOG_EN
    output logic              timeout,
`endif
    output logic              busy
);

    localparam int TMR_MAX = (SETTLE_CYCLES > COOLDOWN_CYCLES) ? SETTLE_CYCLES : COOLDOWN_CYCLES;
    localparam int TMR_W   = timer_width(TMR_MAX);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] COOL_LOAD   = TMR_W'(COOLDOWN_CYCLES - 1);

    state_t r_state;
    logic   r_grant;
    logic   r_last;

    logic [NTANKS-1:0] w_req;
    logic [NTANKS-1:0] w_fault_now;
    logic [NTANKS-1:0] w_wd_lock;
    logic              w_grant;
    logic              w_start;
    logic              w_settle_abort;
    logic              w_settle_done;
    logic              w_pump_stop;
    logic              w_wd_expire;
    logic              w_tmr_load;
    logic              w_tmr_dec;
    logic              w_tmr_done;
    logic [TMR_W-1:0]  w_tmr_val;

    // Faults are taken from the registered latch only, so a new fault acts
    // on the FSM one cycle after it is seen on the sensors.
    assign w_fault_now = caixa_nivel_max & ~caixa_nivel_min;
    assign w_req       = ~caixa_nivel_min & ~inconsistencia;
    // On a tie the tank that was not served last wins; otherwise the sole
    // requester (bit 1 set means tank 1).
    assign w_grant     = (&w_req) ? ~r_last : w_req[1];

    assign w_start        = (r_state == ST_IDLE) && cisterna_nivel_min && (|w_req);
    assign w_settle_abort = ~cisterna_nivel_min | inconsistencia[r_grant];
    assign w_settle_done  = (r_state == ST_SETTLE) && !w_settle_abort && w_tmr_done;
    assign w_pump_stop    = caixa_nivel_max[r_grant] | ~cisterna_nivel_min
                          | inconsistencia[r_grant] | w_wd_expire;

    assign w_tmr_load = w_start || ((r_state == ST_PUMPING) && w_pump_stop);
    assign w_tmr_val  = (r_state == ST_IDLE) ? SETTLE_LOAD : COOL_LOAD;
    assign w_tmr_dec  = (r_state == ST_SETTLE) || (r_state == ST_COOLDOWN);

    recalque_timer #(.WIDTH(TMR_W)) u_timer (
        .i_clk      (clk_2),
        .i_reset    (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_done     (w_tmr_done)
    );

`ifdef RECALQUE_WATCHDOG_EN
    localparam int WD_W = timer_width(MAX_PUMP_CYCLES);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(MAX_PUMP_CYCLES - 1);

    logic w_wd_done;

    recalque_timer #(.WIDTH(WD_W)) u_watchdog (
        .i_clk      (clk_2),
        .i_reset    (reset),
        .i_load     (w_settle_done),
        .i_load_val (WD_LOAD),
        .i_dec      (r_state == ST_PUMPING),
        .o_done     (w_wd_done)
    );

    assign w_wd_expire = (r_state == ST_PUMPING) && w_wd_done;
`else
    assign w_wd_expire = 1'b0;
`endif

    assign w_wd_lock = w_wd_expire ? (r_grant ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_grant        <= 1'b0;
            r_last         <= 1'b1;
            bomba_acionada <= 1'b0;
            valvula_en     <= 1'b0;
            valvula_sel    <= 1'b0;
            inconsistencia <= '0;
            busy           <= 1'b0;
`ifdef RECALQUE_WATCHDOG_EN
            timeout        <= 1'b0;
`endif
        end else begin
            inconsistencia <= inconsistencia | w_fault_now | w_wd_lock;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_grant     <= w_grant;
                        valvula_sel <= w_grant;
                        valvula_en  <= 1'b1;
                        busy        <= 1'b1;
                        r_state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Abort has priority: pump never started, so no cooldown
                    // and the tank keeps its place in the alternation.
                    if (w_settle_abort) begin
                        valvula_en <= 1'b0;
                        busy       <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else if (w_tmr_done) begin
                        bomba_acionada <= 1'b1;
                        r_state        <= ST_PUMPING;
                    end
                end
                ST_PUMPING: begin
                    if (w_pump_stop) begin
                        bomba_acionada <= 1'b0;
                        valvula_en     <= 1'b0;
                        r_last         <= r_grant;
                        r_state        <= ST_COOLDOWN;
`ifdef RECALQUE_WATCHDOG_EN
                        if (w_wd_expire) begin
                            timeout <= 1'b1;
                        end
`endif
                    end
                end
                ST_COOLDOWN: begin
                    if (w_tmr_done) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
